// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- definitions shared by the serial pattern transmitter and the
// shift-register sequence detector benches.
//   seq_state_e  : transmitter FSM states (IDLE, SHIFT, GAP)
//   SEQ_FILL     : level driven on the serial line when no pattern bit is sent
//   SEQ_PAT_1001 : default 4-bit pattern recognised by the detector
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } seq_state_e;

   localparam logic       SEQ_FILL     = 1'b0;
   localparam logic [3:0] SEQ_PAT_1001 = 4'b1001;

endpackage : seq_pkg

// File: rtl/seq_dcnt.sv
// -----------------------------------------------------------------------------
// seq_dcnt -- loadable down-counter with zero flag.
// Load has priority over decrement; decrement saturates at zero so the count
// never wraps.
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset (count -> 0)
//   load     in   1   load load_val this edge
//   load_val in   W   value to load
//   dec      in   1   decrement this edge (ignored while load or at zero)
//   zero     out  1   count is zero
// -----------------------------------------------------------------------------
module seq_dcnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule : seq_dcnt

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx -- serial pattern transmitter.
// Accepts a PAT_W-bit pattern with repeat and gap counts over valid/ready and
// emits it MSB first, one bit per clk, repeating it pat_repeat+1 times with
// pat_gap idle cycles between repetitions.
// Optional feature macro: SEQ_TX_ABORT_EN adds the abort input, which returns
// the FSM to IDLE at the next edge without a done pulse.
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   abort       in   1      (SEQ_TX_ABORT_EN only) cancel the transaction
//   pat_valid   in   1      pat_data/pat_repeat/pat_gap valid
//   pat_ready   out  1      registered; high only in IDLE
//   pat_data    in   PAT_W  pattern, sent MSB first
//   pat_repeat  in   CNT_W  extra repetitions (0 = send once)
//   pat_gap     in   GAP_W  idle cycles between repetitions
//   seq         out  1      serial bit, registered
//   seq_valid   out  1      seq carries a pattern bit
//   busy        out  1      FSM not in IDLE
//   done        out  1      pulse coincident with the final bit
// -----------------------------------------------------------------------------
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SEQ_TX_ABORT_EN
   input  logic             abort,
`endif
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [PAT_W-1:0] pat_data,
   input  logic [CNT_W-1:0] pat_repeat,
   input  logic [GAP_W-1:0] pat_gap,
   output logic             seq,
   output logic             seq_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(PAT_W);

   seq_state_e       state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] sh_q, sh_d;    // bits still to be sent, next one at MSB
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             seq_q, seq_d;
   logic             seq_valid_q, seq_valid_d;
   logic             pat_ready_q, pat_ready_d;

   logic bit_load, bit_dec, bit_zero;
   logic rep_load, rep_dec, rep_zero;
   logic gap_load, gap_dec, gap_zero;
   logic abort_w;

`ifdef SEQ_TX_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Index of the bit currently on seq; zero marks the LSB.
   seq_dcnt #(.W(BIT_W)) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bit_load),
      .load_val (BIT_W'(PAT_W - 1)),
      .dec      (bit_dec),
      .zero     (bit_zero)
   );

   // Repetitions still owed after the current one.
   seq_dcnt #(.W(CNT_W)) u_rep_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rep_load),
      .load_val (pat_repeat),
      .dec      (rep_dec),
      .zero     (rep_zero)
   );

   // Loaded with gap-1 so the zero flag marks the final idle cycle.
   seq_dcnt #(.W(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .load_val (gap_q - 1'b1),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      sh_d        = sh_q;
      gap_d       = gap_q;
      seq_d       = SEQ_FILL;
      seq_valid_d = 1'b0;
      bit_load    = 1'b0;
      bit_dec     = 1'b0;
      rep_load    = 1'b0;
      rep_dec     = 1'b0;
      gap_load    = 1'b0;
      gap_dec     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pat_valid && pat_ready_q) begin
               pat_d       = pat_data;
               gap_d       = pat_gap;
               sh_d        = pat_data << 1;
               seq_d       = pat_data[PAT_W-1];
               seq_valid_d = 1'b1;
               bit_load    = 1'b1;
               rep_load    = 1'b1;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (!bit_zero) begin
               seq_d       = sh_q[PAT_W-1];
               sh_d        = sh_q << 1;
               seq_valid_d = 1'b1;
               bit_dec     = 1'b1;
            end else if (rep_zero) begin
               state_d = IDLE;
            end else begin
               rep_dec = 1'b1;
               if (gap_q == '0) begin
                  // Back-to-back: MSB of the next copy follows the LSB directly.
                  seq_d       = pat_q[PAT_W-1];
                  sh_d        = pat_q << 1;
                  seq_valid_d = 1'b1;
                  bit_load    = 1'b1;
               end else begin
                  gap_load = 1'b1;
                  state_d  = GAP;
               end
            end
         end
         GAP: begin
            if (gap_zero) begin
               seq_d       = pat_q[PAT_W-1];
               sh_d        = pat_q << 1;
               seq_valid_d = 1'b1;
               bit_load    = 1'b1;
               state_d     = SHIFT;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a handshake in IDLE.
      if (abort_w) begin
         state_d     = IDLE;
         seq_d       = SEQ_FILL;
         seq_valid_d = 1'b0;
         bit_load    = 1'b0;
         rep_load    = 1'b0;
         gap_load    = 1'b0;
      end

      pat_ready_d = (state_d == IDLE);
   end

   // NOTE: all control and datapath flops are reset; pat_ready comes up low
   // and rises one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         sh_q        <= '0;
         gap_q       <= '0;
         seq_q       <= SEQ_FILL;
         seq_valid_q <= 1'b0;
         pat_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         sh_q        <= sh_d;
         gap_q       <= gap_d;
         seq_q       <= seq_d;
         seq_valid_q <= seq_valid_d;
         pat_ready_q <= pat_ready_d;
      end
   end

   assign pat_ready = pat_ready_q;
   assign seq       = seq_q;
   assign seq_valid = seq_valid_q;
   assign busy      = (state_q != IDLE);
   // Decoded from flops: high exactly while the LSB of the last copy is on seq.
   assign done      = (state_q == SHIFT) && bit_zero && rep_zero && !abort_w;

endmodule : seq_pattern_tx
